clk_en_sched: RTL

//  Clock-enable scheduler for the clk100 domain; replaces derived clocks with single-cycle enables.

---
 rtl/clk_en_sched.sv | 127 ++++++++++++
 1 files changed

// File: rtl/clk_en_sched.sv
// rtl/clk_en_sched.sv - clk100 clock-enable scheduler: pixel enable, paced game step tick, runtime period config
// Optional single-step pulse input is enabled by defining CLK_SCHED_SINGLE_STEP_EN.
module clk_en_sched #(
    parameter int          PERIOD_W   = 32,
    parameter int unsigned DEF_PERIOD = 25_000_000,
    parameter int unsigned MIN_PERIOD = 4
) (
    input  logic                clk100,
    input  logic                rst,
    input  logic                run,
    input  logic                cfg_valid,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                cfg_ready,
    output logic                pix_en,
    output logic                step_tick,
    output logic [15:0]         tick_cnt,
    output logic [1:0]          state
`ifdef CLK_SCHED_SINGLE_STEP_EN
    ,
    input  logic                single_step
`endif
);

    localparam logic [PERIOD_W-1:0] DEF_P = PERIOD_W'(DEF_PERIOD);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} run_t;

    run_t                run_st, run_nx;
    logic [1:0]          pix_cnt;
    logic [PERIOD_W-1:0] step_cnt, period, pend_period;
    logic                pend, done;
    logic                running, terminal, xfer, apply, ss_fire;
    logic [PERIOD_W-1:0] clamped;

    always_ff @(posedge clk100) begin
        if (rst) run_st <= IDLE;
        else     run_st <= run_nx;
    end

    always_comb begin
        run_nx = run_st;
        case (run_st)
            IDLE:    if (run)  run_nx = RUN;
            RUN:     if (!run) run_nx = IDLE;
            default: run_nx = IDLE;
        endcase
    end

    always_comb begin
        state = {pend, run_st == RUN};
    end

    always_ff @(posedge clk100) begin
        if (rst) begin
            pix_cnt <= 2'd0;
            pix_en  <= 1'b0;
        end else begin
            pix_cnt <= pix_cnt + 2'd1;
            pix_en  <= (pix_cnt == 2'd3);
        end
    end

`ifdef CLK_SCHED_SINGLE_STEP_EN
    logic ss_d, ss_req;
    // Rising edge is qualified by IDLE when seen, then fires one edge later.
    always_ff @(posedge clk100) begin
        if (rst) begin
            ss_d   <= 1'b0;
            ss_req <= 1'b0;
        end else begin
            ss_d   <= single_step;
            ss_req <= single_step & ~ss_d & ~running;
        end
    end
    assign ss_fire = ss_req;
`else
    assign ss_fire = 1'b0;
`endif

    assign running  = (run_st == RUN);
    assign terminal = running && (step_cnt == period - ONE);
    assign xfer     = cfg_valid && cfg_ready;
    // A pending period lands on a RUN terminal count, or immediately when paused.
    assign apply    = pend && !done && (terminal || !running);
    assign clamped  = (cfg_period < MIN_P) ? MIN_P : cfg_period;

    always_ff @(posedge clk100) begin
        if (rst) begin
            step_cnt    <= '0;
            period      <= DEF_P;
            pend_period <= DEF_P;
            pend        <= 1'b0;
            done        <= 1'b0;
            cfg_ready   <= 1'b0;
            step_tick   <= 1'b0;
            tick_cnt    <= 16'd0;
        end else begin
            step_tick <= terminal || ss_fire;
            if (terminal || ss_fire) tick_cnt <= tick_cnt + 16'd1;

            if (terminal)     step_cnt <= '0;
            else if (running) step_cnt <= step_cnt + ONE;

            if (apply) begin
                period <= pend_period;
                done   <= 1'b1;
                if (!running) step_cnt <= '0;
            end

            // pend drops one edge after the new period takes effect.
            if (done) begin
                pend <= 1'b0;
                done <= 1'b0;
            end

            if (xfer) begin
                pend        <= 1'b1;
                pend_period <= clamped;
            end

            cfg_ready <= xfer ? 1'b0 : (!pend || done);
        end
    end

endmodule
